// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment read-back path: widths, segment codes,
// FSM states and the segment-to-digit decoder.
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    // Active-high segment codes, bit 0 = a ... bit 6 = g.
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {SETTLE, LOCKED} state_t;

    typedef struct packed {
        logic               known;
        logic               blank;
        logic [DIGIT_W-1:0] digit;
    } decode_t;

    function automatic decode_t seg_to_digit(input logic [SEG_W-1:0] seg);
        decode_t d;
        d = '{known: 1'b1, blank: 1'b0, digit: '0};
        case (seg)
            SEG_0: d.digit = 4'h0;
            SEG_1: d.digit = 4'h1;
            SEG_2: d.digit = 4'h2;
            SEG_3: d.digit = 4'h3;
            SEG_4: d.digit = 4'h4;
            SEG_5: d.digit = 4'h5;
            SEG_6: d.digit = 4'h6;
            SEG_7: d.digit = 4'h7;
            SEG_8: d.digit = 4'h8;
            SEG_9: d.digit = 4'h9;
            SEG_A: d.digit = 4'hA;
            SEG_B: d.digit = 4'hB;
            SEG_C: d.digit = 4'hC;
            SEG_D: d.digit = 4'hD;
            SEG_E: d.digit = 4'hE;
            SEG_F: d.digit = 4'hF;
            SEG_BLANK: begin
                d.known = 1'b0;
                d.blank = 1'b1;
            end
            default: d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_sync.sv
// Multi-flop synchronizer for an asynchronous vector; q is the last stage.
module seg_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // NOTE: these are individual flops, not a RAM, so clearing every stage on
    // reset is cheap and keeps the chain contents deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, which is what forms the shift chain.
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/seg7_capture.sv
// Samples an asynchronous 7-segment bus, waits for a stable pattern, decodes it
// and delivers one event per distinct pattern through a one-entry valid/ready register.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEG_W-1:0]   seg,
    input  logic               out_ready,
    input  logic               clr_ovf,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] out_digit,
    output logic               out_known,
    output logic               out_blank,
    output logic [SEG_W-1:0]   out_raw,
    output logic               overflow
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] sync_q, cand, last;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sync_vld, cand_vld, reported;
    logic             reload, hit, accept, evt;
    state_t           state, state_next;
    decode_t          dec;

    seg_sync #(.WIDTH(SEG_W), .STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .d(seg), .q(sync_q)
    );

    // Chain contents are meaningless until it has filled with real samples;
    // a parallel chain of ones marks when sync_q starts carrying seg.
    seg_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_fill (
        .clk(clk), .rst_n(rst_n), .d(1'b1), .q(sync_vld)
    );

    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and infers a latch.
    always_comb begin
        reload     = !cand_vld || (sync_q != cand);
        cnt_next   = cnt;
        state_next = state;
        accept     = 1'b0;
        if (reload) cnt_next = '0;
        else if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
        // The current sample is the STABLE_CYCLES-th identical one.
        hit = sync_vld && (cnt_next == CNT_MAX) && (reload || (cnt != CNT_MAX));
        case (state)
            SETTLE: if (hit) begin
                accept     = 1'b1;
                state_next = LOCKED;
            end
            LOCKED: if (sync_vld && reload) begin
                state_next = SETTLE;
                if (hit) begin
                    accept     = 1'b1;
                    state_next = LOCKED;
                end
            end
            default: state_next = SETTLE;
        endcase
        evt = accept && (!reported || (sync_q != last));
        dec = seg_to_digit(sync_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand     <= '0;
            cnt      <= '0;
            cand_vld <= 1'b0;
            state    <= SETTLE;
            last     <= '0;
            reported <= 1'b0;
        end else begin
            if (sync_vld) begin
                cand     <= sync_q;
                cnt      <= cnt_next;
                cand_vld <= 1'b1;
            end
            state <= state_next;
            if (accept) begin
                last     <= sync_q;
                reported <= 1'b1;
            end
        end
    end

    // One-entry output register; an event arriving while the held one is
    // stalled is dropped and flagged, a simultaneous accept reloads with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_digit <= '0;
            out_known <= 1'b0;
            out_blank <= 1'b0;
            out_raw   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (clr_ovf) overflow <= 1'b0;
            if (evt && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_digit <= dec.digit;
                out_known <= dec.known;
                out_blank <= dec.blank;
                out_raw   <= sync_q;
            end else if (evt) begin
                overflow <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
